// File: rtl/seu_pipe.sv
// Buffered LEGv8 sign-extension unit: decodes the immediate of B/CB/I/D/IW formats
// and queues results with illegal flags in a small FIFO with valid/ready on both sides.
module seu_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [25:0]               instruction,
  input  logic [2:0]                seu_op,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     extended_address,
  output logic                      illegal_op,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("seu_pipe: DATA_WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seu_pipe: DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_CB = 3'b001,
    OP_I  = 3'b010,
    OP_D  = 3'b011,
    OP_IW = 3'b100
  } seu_op_t;

  seu_op_t                 op;
  logic [DATA_WIDTH-1:0]   ext;
  logic                    ill;
  logic [15:0]             imm16;
  logic [1:0]              hw;

  assign op    = seu_op_t'(seu_op);
  assign imm16 = instruction[20:5];
  assign hw    = instruction[22:21];

  always_comb begin
    ext = '0;
    ill = 1'b0;
    case (op)
      OP_B:  ext = {{(DATA_WIDTH-28){instruction[25]}}, instruction[25:0], 2'b00};
      OP_CB: ext = {{(DATA_WIDTH-21){instruction[23]}}, instruction[23:5], 2'b00};
      OP_I:  ext = {{(DATA_WIDTH-12){1'b0}}, instruction[21:10]};
      OP_D:  ext = {{(DATA_WIDTH-9){instruction[20]}}, instruction[20:12]};
      OP_IW: begin
        // a 32-bit datapath only has halfword slots 0 and 1
        if (DATA_WIDTH == 32 && hw[1]) begin
          ill = 1'b1;
        end else begin
          ext = DATA_WIDTH'(imm16) << {hw, 4'b0000};
        end
      end
      default: ill = 1'b1;
    endcase
  end

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_ill  [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= ext;
      mem_ill[wr_ptr]  <= ill;
    end
  end

  // storage is unreset; gating on out_valid keeps outputs zero when empty
  assign extended_address = out_valid ? mem_data[rd_ptr] : '0;
  assign illegal_op       = out_valid ? mem_ill[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_seu_pipe.sv
// Directed bench for seu_pipe: runs a 64-bit and a 32-bit instance side by side on shared stimulus.
module tb_seu_pipe;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, flush, out_ready;
  logic [25:0] instruction;
  logic [2:0]  seu_op;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] ext64;
  logic [1:0]  count64;
  logic        in_ready32, out_valid32, ill32;
  logic [31:0] ext32;
  logic [1:0]  count32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seu_pipe #(.DATA_WIDTH(64), .DEPTH(2)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .seu_op(seu_op), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready),
    .extended_address(ext64), .illegal_op(ill64), .count(count64)
  );

  seu_pipe #(.DATA_WIDTH(32), .DEPTH(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instruction(instruction), .seu_op(seu_op), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready),
    .extended_address(ext32), .illegal_op(ill32), .count(count32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instruction = '0; seu_op = 3'b000;
    #3;
    tests++; if (out_valid64 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid64); end
    tests++; if (in_ready64 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready64); end
    tests++; if (count64 !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count64); end
    tests++; if (ext64 !== 64'h0 || ill64 !== 1'b0) begin fails++; $display("FAIL reset_outputs: got %h/%b want 0/0", ext64, ill64); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_b_format();
    instruction = 26'h3FFFFFF; seu_op = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid64 !== 1'b1) begin fails++; $display("FAIL b_valid: got %b want 1", out_valid64); end
    tests++; if (ext64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL b_ext64: got %h want fffffffffffffffc", ext64); end
    tests++; if (ext32 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL b_ext32: got %h want fffffffc", ext32); end
    tests++; if (ill64 !== 1'b0) begin fails++; $display("FAIL b_ill: got %b want 0", ill64); end
    tick();
    tests++; if (out_valid64 !== 1'b0) begin fails++; $display("FAIL b_drained: got %b want 0", out_valid64); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    seu_op = 3'b001; instruction = 26'h0800000;
    tick();
    tests++; if (out_valid64 !== 1'b1 || ext64 !== 64'hFFFF_FFFF_FFF0_0000) begin fails++; $display("FAIL cb_ext64: got %b/%h want 1/fffffffffff00000", out_valid64, ext64); end
    tests++; if (ext32 !== 32'hFFF0_0000) begin fails++; $display("FAIL cb_ext32: got %h want fff00000", ext32); end
    seu_op = 3'b010; instruction = 26'h03FFC00;
    tick();
    tests++; if (out_valid64 !== 1'b1 || ext64 !== 64'h0000_0000_0000_0FFF) begin fails++; $display("FAIL i_ext64: got %b/%h want 1/0000000000000fff", out_valid64, ext64); end
    tests++; if (count64 !== 2'd1) begin fails++; $display("FAIL b2b_count: got %0d want 1", count64); end
    seu_op = 3'b011; instruction = 26'h0100000;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid64 !== 1'b1 || ext64 !== 64'hFFFF_FFFF_FFFF_FF00) begin fails++; $display("FAIL d_ext64: got %b/%h want 1/ffffffffffffff00", out_valid64, ext64); end
    tests++; if (ext32 !== 32'hFFFF_FF00) begin fails++; $display("FAIL d_ext32: got %h want ffffff00", ext32); end
    tick();
    tests++; if (out_valid64 !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b want 0", out_valid64); end
  endtask

  task automatic test_iw();
    out_ready = 1'b1; in_valid = 1'b1; seu_op = 3'b100;
    instruction = 26'h07579A0;
    tick();
    tests++; if (ext64 !== 64'hABCD_0000_0000_0000 || ill64 !== 1'b0) begin fails++; $display("FAIL iw_hw3_64: got %h/%b want abcd000000000000/0", ext64, ill64); end
    tests++; if (ext32 !== 32'h0 || ill32 !== 1'b1) begin fails++; $display("FAIL iw_hw3_32: got %h/%b want 00000000/1", ext32, ill32); end
    instruction = 26'h05579A0;
    tick();
    tests++; if (ext64 !== 64'h0000_ABCD_0000_0000 || ill64 !== 1'b0) begin fails++; $display("FAIL iw_hw2_64: got %h/%b want 0000abcd00000000/0", ext64, ill64); end
    tests++; if (ext32 !== 32'h0 || ill32 !== 1'b1) begin fails++; $display("FAIL iw_hw2_32: got %h/%b want 00000000/1", ext32, ill32); end
    instruction = 26'h03579A0;
    tick();
    tests++; if (ext32 !== 32'hABCD_0000 || ill32 !== 1'b0) begin fails++; $display("FAIL iw_hw1_32: got %h/%b want abcd0000/0", ext32, ill32); end
    seu_op = 3'b111; instruction = 26'h3FFFFFF;
    tick();
    tests++; if (ext64 !== 64'h0 || ill64 !== 1'b1 || out_valid64 !== 1'b1) begin fails++; $display("FAIL op111_64: got %h/%b/%b want 0/1/1", ext64, ill64, out_valid64); end
    seu_op = 3'b101; instruction = 26'h0000001;
    tick();
    in_valid = 1'b0;
    tests++; if (ext32 !== 32'h0 || ill32 !== 1'b1) begin fails++; $display("FAIL op101_32: got %h/%b want 0/1", ext32, ill32); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; seu_op = 3'b000;
    instruction = 26'd1;
    tick();
    tests++; if (count64 !== 2'd1 || in_ready64 !== 1'b1 || ext64 !== 64'd4) begin fails++; $display("FAIL bp_first: got cnt %0d rdy %b ext %h want 1/1/4", count64, in_ready64, ext64); end
    instruction = 26'd2;
    tick();
    tests++; if (count64 !== 2'd2 || in_ready64 !== 1'b0) begin fails++; $display("FAIL bp_full: got cnt %0d rdy %b want 2/0", count64, in_ready64); end
    instruction = 26'd3;
    tick();
    tests++; if (count64 !== 2'd2 || ext64 !== 64'd4 || out_valid64 !== 1'b1) begin fails++; $display("FAIL bp_hold: got cnt %0d ext %h want 2/4", count64, ext64); end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (count64 !== 2'd1 || in_ready64 !== 1'b1 || ext64 !== 64'd8) begin fails++; $display("FAIL bp_pop1: got cnt %0d rdy %b ext %h want 1/1/8", count64, in_ready64, ext64); end
    tick();
    tests++; if (count64 !== 2'd0 || out_valid64 !== 1'b0 || ext64 !== 64'h0) begin fails++; $display("FAIL bp_pop2: got cnt %0d vld %b ext %h want 0/0/0", count64, out_valid64, ext64); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; seu_op = 3'b000;
    instruction = 26'd5; tick();
    instruction = 26'd6; tick();
    tests++; if (count64 !== 2'd2) begin fails++; $display("FAIL fl_prefill: got %0d want 2", count64); end
    flush = 1'b1; instruction = 26'd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (count64 !== 2'd0 || out_valid64 !== 1'b0 || ext64 !== 64'h0) begin fails++; $display("FAIL fl_empty: got cnt %0d vld %b ext %h want 0/0/0", count64, out_valid64, ext64); end
    tests++; if (count32 !== 2'd0 || out_valid32 !== 1'b0) begin fails++; $display("FAIL fl_empty32: got cnt %0d vld %b want 0/0", count32, out_valid32); end
    in_valid = 1'b1; instruction = 26'd8;
    tick();
    in_valid = 1'b0;
    tests++; if (count64 !== 2'd1 || ext64 !== 64'd32) begin fails++; $display("FAIL fl_repush: got cnt %0d ext %h want 1/20", count64, ext64); end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid64 !== 1'b0) begin fails++; $display("FAIL fl_drain: got %b want 0", out_valid64); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; seu_op = 3'b000; instruction = 26'd9;
    tick();
    in_valid = 1'b0;
    tests++; if (count64 !== 2'd1 || ext64 !== 64'd36) begin fails++; $display("FAIL ar_pre: got cnt %0d ext %h want 1/24", count64, ext64); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (out_valid64 !== 1'b0 || ext64 !== 64'h0 || count64 !== 2'd0) begin fails++; $display("FAIL ar_async: got vld %b ext %h cnt %0d want 0/0/0", out_valid64, ext64, count64); end
    tests++; if (out_valid32 !== 1'b0 || ext32 !== 32'h0) begin fails++; $display("FAIL ar_async32: got vld %b ext %h want 0/0", out_valid32, ext32); end
    #2 reset_n = 1'b1;
    in_valid = 1'b1; instruction = 26'd10;
    tick();
    in_valid = 1'b0;
    tests++; if (count64 !== 2'd1 || ext64 !== 64'd40 || ill64 !== 1'b0) begin fails++; $display("FAIL ar_new: got cnt %0d ext %h ill %b want 1/28/0", count64, ext64, ill64); end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid64 !== 1'b0 || ext64 !== 64'h0) begin fails++; $display("FAIL ar_nostale: got vld %b ext %h want 0/0", out_valid64, ext64); end
  endtask

  initial begin
    test_reset();
    test_b_format();
    test_back_to_back();
    test_iw();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
